// File: rtl/hit_judge.sv
// hit_judge: debounces four lane keys and judges them against one scrolling note row,
// producing hit/miss/retire pulses plus saturating score and combo tracking.
module hit_judge #(
  parameter int HIT_Y           = 40,
  parameter int PERFECT_WIN     = 4,
  parameter int GOOD_WIN        = 12,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic        clock_24_i,
  input  logic        reset_n_i,
  input  logic [3:0]  keys_i,
  input  logic [3:0]  command_i,
  input  logic [7:0]  y_pos_i,
  input  logic        note_valid_i,
  output logic        hit_perfect_o,
  output logic        hit_good_o,
  output logic        miss_o,
  output logic        retire_o,
  output logic [15:0] score_o,
  output logic [7:0]  combo_o,
  output logic [7:0]  max_combo_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [8:0] HY = 9'(HIT_Y);
  localparam logic signed [8:0] GW = 9'(GOOD_WIN);
  localparam logic signed [8:0] PW = 9'(PERFECT_WIN);

  typedef enum logic [1:0] {WAIT, OPEN, DONE} state_t;
  state_t state_q, state_d;

  logic [3:0] sync1_q, sync2_q, deb_q, deb_d, press_q, press_d, mask_q, mask_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic signed [8:0] d;
  logic in_win, in_perf, above, opn, hit, leave, wrong;
  logic perf_q, perf_d, good_q, good_d, miss_q, miss_d, retire_q, retire_d;
  logic [15:0] score_q, score_d;
  logic [7:0] combo_q, combo_d, max_q, max_d, combo_base;
  logic [16:0] sum;

  // Debounced state is active-high "pressed"; raw keys are active-low.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (~sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = ~sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  assign d       = $signed({1'b0, y_pos_i}) - HY;
  assign in_win  = (d >= -GW) && (d <= GW);
  assign in_perf = (d >= -PW) && (d <= PW);
  assign above   = d > GW;
  assign opn     = state_q == OPEN;
  assign wrong   = opn && |(press_q & ~command_i);
  assign hit     = opn && in_win && |command_i && ((mask_q | (press_q & command_i)) == command_i);
  assign leave   = opn && !hit && (!in_win || !note_valid_i);

  always_ff @(posedge clock_24_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      deb_q    <= '0;
      press_q  <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q  <= WAIT;
      mask_q   <= '0;
      perf_q   <= 1'b0;
      good_q   <= 1'b0;
      miss_q   <= 1'b0;
      retire_q <= 1'b0;
      score_q  <= '0;
      combo_q  <= '0;
      max_q    <= '0;
    end else begin
      sync1_q  <= keys_i;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      press_q  <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      mask_q   <= mask_d;
      perf_q   <= perf_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      retire_q <= retire_d;
      score_q  <= score_d;
      combo_q  <= combo_d;
      max_q    <= max_d;
    end
  end

  always_comb begin
    state_d = (state_q == WAIT) ? ((note_valid_i && in_win) ? OPEN : WAIT)
            : opn ? ((hit || leave) ? DONE : OPEN)
            : ((!note_valid_i || above) ? WAIT : DONE);
  end

  // A wrong-lane press clears combo before a same-cycle hit increments it.
  always_comb begin
    mask_d     = opn ? (mask_q | (press_q & command_i)) : 4'd0;
    perf_d     = hit && in_perf;
    good_d     = hit && !in_perf;
    miss_d     = leave && |command_i;
    retire_d   = hit || leave;
    sum        = {1'b0, score_q} + (in_perf ? 17'd100 : 17'd50);
    score_d    = !hit ? score_q : sum[16] ? 16'hFFFF : sum[15:0];
    combo_base = wrong ? 8'd0 : combo_q;
    combo_d    = hit ? ((combo_base == 8'hFF) ? 8'hFF : combo_base + 8'd1)
               : (wrong || miss_d) ? 8'd0 : combo_q;
    max_d      = (combo_d > max_q) ? combo_d : max_q;
  end

  assign hit_perfect_o = perf_q;
  assign hit_good_o    = good_q;
  assign miss_o        = miss_q;
  assign retire_o      = retire_q;
  assign score_o       = score_q;
  assign combo_o       = combo_q;
  assign max_combo_o   = max_q;
endmodule
